// File: rtl/mips_chk_pkg.sv
// Shared encodings for the MIPS data-memory write checker: FSM states and fail codes.
package mips_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } chkState_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_ILLEGAL  = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/chk_match_unit.sv
// Combinational comparator of one bus write against the expected-write table.
// Only unmatched entries are candidates; in ordered mode just entry matchCnt is.
module chk_match_unit
  import mips_chk_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IDX_W      = 2,
  parameter int ORDERED    = 1
) (
  input  logic [NUM_CHECKS-1:0][ADDR_W-1:0] tabAddr,
  input  logic [NUM_CHECKS-1:0][DATA_W-1:0] tabData,
  input  logic [NUM_CHECKS-1:0]             matched,
  input  logic [IDX_W:0]                    matchCnt,
  input  logic [ADDR_W-1:0]                 busAddr,
  input  logic [DATA_W-1:0]                 busData,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hitIdx,
  output logic                              addrHit
);

  logic [NUM_CHECKS-1:0] cand;
  logic [NUM_CHECKS-1:0] addrEq;
  logic [NUM_CHECKS-1:0] fullEq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
      if (ORDERED != 0) begin : g_ord
        assign cand[gi] = ~matched[gi] & (matchCnt == (IDX_W+1)'(gi));
      end else begin : g_any
        assign cand[gi] = ~matched[gi];
      end
      assign addrEq[gi] = cand[gi] & (tabAddr[gi] == busAddr);
      assign fullEq[gi] = addrEq[gi] & (tabData[gi] == busData);
    end
  endgenerate

  assign hit     = |fullEq;
  assign addrHit = |addrEq;

  // Scan downwards so the lowest matching index is the one that sticks.
  always_comb begin
    hitIdx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (fullEq[i]) hitIdx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor on the MIPS data-memory write bus: programmable expected-write
// table, watchdog and pass/fail status. Define CHECKER_CAPTURE_EN for fail_addr/fail_data.
module mem_write_checker
  import mips_chk_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IDX_W      = 2,
  parameter int ORDERED    = 1,
  parameter int STRICT     = 0,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W:0]    match_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
`ifdef CHECKER_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   LAST_CNT    = (IDX_W+1)'(NUM_CHECKS - 1);

  chkState_t               stateReg, stateNext;
  logic [IDX_W:0]          matchCntReg, matchCntNext;
  logic [CNT_W-1:0]        cycleCntReg, cycleCntNext;
  logic [1:0]              failCodeReg, failCodeNext;
  logic [NUM_CHECKS-1:0]   matchedReg, matchedNext;
`ifdef CHECKER_CAPTURE_EN
  logic [ADDR_W-1:0]       failAddrReg, failAddrNext;
  logic [DATA_W-1:0]       failDataReg, failDataNext;
`endif

  logic [NUM_CHECKS-1:0][ADDR_W-1:0] tabAddr;
  logic [NUM_CHECKS-1:0][DATA_W-1:0] tabData;
  logic                              tableWe;
  logic                              hit;
  logic                              addrHit;
  logic [IDX_W-1:0]                  hitIdx;

  // The table is frozen while a run is in progress and deliberately survives reset.
  assign tableWe = exp_we && (stateReg != RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_tab
      always_ff @(posedge clk) begin
        if (tableWe && (exp_idx == IDX_W'(gi))) begin
          tabAddr[gi] <= exp_addr;
          tabData[gi] <= exp_data;
        end
      end
    end
  endgenerate

  chk_match_unit #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W),
    .ORDERED    (ORDERED)
  ) u_match (
    .tabAddr  (tabAddr),
    .tabData  (tabData),
    .matched  (matchedReg),
    .matchCnt (matchCntReg),
    .busAddr  (DataAddr),
    .busData  (WriteData),
    .hit      (hit),
    .hitIdx   (hitIdx),
    .addrHit  (addrHit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg    <= IDLE;
      matchCntReg <= '0;
      cycleCntReg <= '0;
      failCodeReg <= FC_NONE;
      matchedReg  <= '0;
`ifdef CHECKER_CAPTURE_EN
      failAddrReg <= '0;
      failDataReg <= '0;
`endif
    end else begin
      stateReg    <= stateNext;
      matchCntReg <= matchCntNext;
      cycleCntReg <= cycleCntNext;
      failCodeReg <= failCodeNext;
      matchedReg  <= matchedNext;
`ifdef CHECKER_CAPTURE_EN
      failAddrReg <= failAddrNext;
      failDataReg <= failDataNext;
`endif
    end
  end

  always_comb begin
    stateNext    = stateReg;
    matchCntNext = matchCntReg;
    cycleCntNext = cycleCntReg;
    failCodeNext = failCodeReg;
    matchedNext  = matchedReg;
`ifdef CHECKER_CAPTURE_EN
    failAddrNext = failAddrReg;
    failDataNext = failDataReg;
`endif
    if (start) begin
      stateNext    = RUN;
      matchCntNext = '0;
      cycleCntNext = '0;
      failCodeNext = FC_NONE;
      matchedNext  = '0;
`ifdef CHECKER_CAPTURE_EN
      failAddrNext = '0;
      failDataNext = '0;
`endif
    end else if (stateReg == RUN) begin
      if (cycleCntReg != CNT_MAX) cycleCntNext = cycleCntReg + 1'b1;
      if (MemWrite) begin
        if (hit) begin
          for (int i = 0; i < NUM_CHECKS; i++) begin
            if (hitIdx == IDX_W'(i)) matchedNext[i] = 1'b1;
          end
          matchCntNext = matchCntReg + 1'b1;
          if (matchCntReg == LAST_CNT) stateNext = PASS;
        end else if (addrHit || (STRICT != 0)) begin
          stateNext    = FAIL;
          failCodeNext = addrHit ? FC_MISMATCH : FC_ILLEGAL;
`ifdef CHECKER_CAPTURE_EN
          failAddrNext = DataAddr;
          failDataNext = WriteData;
`endif
        end
      end
      // A final match on the last allowed cycle still counts as a pass.
      if ((cycleCntReg == TIMEOUT_CNT) && (stateNext != PASS)) begin
        stateNext    = FAIL;
        failCodeNext = FC_TIMEOUT;
`ifdef CHECKER_CAPTURE_EN
        failAddrNext = '0;
        failDataNext = '0;
`endif
      end
    end
  end

  assign busy      = (stateReg == RUN);
  assign done      = (stateReg == PASS) || (stateReg == FAIL);
  assign pass      = (stateReg == PASS);
  assign fail_code = failCodeReg;
  assign match_cnt = matchCntReg;
  assign cycle_cnt = cycleCntReg;
`ifdef CHECKER_CAPTURE_EN
  assign fail_addr = failAddrReg;
  assign fail_data = failDataReg;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed vector bench for mem_write_checker: three instances cover single-entry
// with short watchdog, ordered lenient, and unordered strict configurations.
module tb_mem_write_checker;

  localparam int NU = 3;
  localparam int UA = 0;  // NUM_CHECKS=1, ORDERED=1, STRICT=0, TIMEOUT=20
  localparam int UB = 1;  // NUM_CHECKS=2, ORDERED=1, STRICT=0
  localparam int UC = 2;  // NUM_CHECKS=2, ORDERED=0, STRICT=1

  localparam int OP_LOAD  = 0;
  localparam int OP_START = 1;
  localparam int OP_WR    = 2;
  localparam int OP_NOP   = 3;

  typedef struct {
    int          unit;
    int          op;
    logic        idx;
    logic [31:0] addr;
    logic [31:0] data;
    int          n;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic [1:0]  mc;
    logic [15:0] cc;
    logic [31:0] fa;
    logic [31:0] fd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [NU-1:0] startV;
  logic [NU-1:0] weV;
  logic          expIdx;
  logic [31:0]   expAddr;
  logic [31:0]   expData;
  logic          memWrite;
  logic [31:0]   dataAddr;
  logic [31:0]   writeData;

  logic          busyV [NU];
  logic          doneV [NU];
  logic          passV [NU];
  logic [1:0]    fcV   [NU];
  logic [1:0]    mcV   [NU];
  logic [15:0]   ccV   [NU];
`ifdef CHECKER_CAPTURE_EN
  logic [31:0]   faV   [NU];
  logic [31:0]   fdV   [NU];
`endif

  int   nChecks = 0;
  int   nErr    = 0;
  vec_t vq[$];

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(1), .IDX_W(1),
    .ORDERED(1), .STRICT(0), .TIMEOUT(20), .CNT_W(16)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .start(startV[UA]),
    .exp_we(weV[UA]), .exp_idx(expIdx), .exp_addr(expAddr), .exp_data(expData),
    .MemWrite(memWrite), .DataAddr(dataAddr), .WriteData(writeData),
    .busy(busyV[UA]), .done(doneV[UA]), .pass(passV[UA]),
    .fail_code(fcV[UA]), .match_cnt(mcV[UA]), .cycle_cnt(ccV[UA])
`ifdef CHECKER_CAPTURE_EN
    , .fail_addr(faV[UA]), .fail_data(fdV[UA])
`endif
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(2), .IDX_W(1),
    .ORDERED(1), .STRICT(0), .TIMEOUT(1000), .CNT_W(16)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .start(startV[UB]),
    .exp_we(weV[UB]), .exp_idx(expIdx), .exp_addr(expAddr), .exp_data(expData),
    .MemWrite(memWrite), .DataAddr(dataAddr), .WriteData(writeData),
    .busy(busyV[UB]), .done(doneV[UB]), .pass(passV[UB]),
    .fail_code(fcV[UB]), .match_cnt(mcV[UB]), .cycle_cnt(ccV[UB])
`ifdef CHECKER_CAPTURE_EN
    , .fail_addr(faV[UB]), .fail_data(fdV[UB])
`endif
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(2), .IDX_W(1),
    .ORDERED(0), .STRICT(1), .TIMEOUT(1000), .CNT_W(16)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .start(startV[UC]),
    .exp_we(weV[UC]), .exp_idx(expIdx), .exp_addr(expAddr), .exp_data(expData),
    .MemWrite(memWrite), .DataAddr(dataAddr), .WriteData(writeData),
    .busy(busyV[UC]), .done(doneV[UC]), .pass(passV[UC]),
    .fail_code(fcV[UC]), .match_cnt(mcV[UC]), .cycle_cnt(ccV[UC])
`ifdef CHECKER_CAPTURE_EN
    , .fail_addr(faV[UC]), .fail_data(fdV[UC])
`endif
  );

  function automatic vec_t mkV(input int u, input int op, input logic idx,
                               input logic [31:0] a, input logic [31:0] d, input int n,
                               input logic b, input logic dn, input logic p,
                               input logic [1:0] fc, input logic [1:0] mc,
                               input logic [15:0] cc, input logic [31:0] fa,
                               input logic [31:0] fd);
    vec_t v;
    v.unit = u; v.op = op; v.idx = idx; v.addr = a; v.data = d; v.n = n;
    v.busy = b; v.done = dn; v.pass = p; v.fc = fc; v.mc = mc; v.cc = cc;
    v.fa = fa; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic checkUnit(input string tag, input int u, input vec_t v);
    chk({tag, ".busy"}, 32'(busyV[u]), 32'(v.busy));
    chk({tag, ".done"}, 32'(doneV[u]), 32'(v.done));
    chk({tag, ".pass"}, 32'(passV[u]), 32'(v.pass));
    chk({tag, ".fail_code"}, 32'(fcV[u]), 32'(v.fc));
    chk({tag, ".match_cnt"}, 32'(mcV[u]), 32'(v.mc));
    chk({tag, ".cycle_cnt"}, 32'(ccV[u]), 32'(v.cc));
`ifdef CHECKER_CAPTURE_EN
    chk({tag, ".fail_addr"}, faV[u], v.fa);
    chk({tag, ".fail_data"}, fdV[u], v.fd);
`endif
  endtask

  task automatic runVec(input int i);
    vec_t v;
    int   cyc;
    v = vq[i];
    case (v.op)
      OP_LOAD: begin
        weV[v.unit] = 1'b1; expIdx = v.idx; expAddr = v.addr; expData = v.data;
      end
      OP_START: startV[v.unit] = 1'b1;
      OP_WR: begin
        memWrite = 1'b1; dataAddr = v.addr; writeData = v.data;
      end
      default: ;
    endcase
    cyc = (v.op == OP_NOP) ? v.n : 1;
    repeat (cyc) @(posedge clk);
    #1;
    weV = '0; startV = '0; memWrite = 1'b0;
    $display("vec %0d unit=%0d op=%0d busy=%0b done=%0b pass=%0b fc=%0d mc=%0d cc=%0d",
             i, v.unit, v.op, busyV[v.unit], doneV[v.unit], passV[v.unit],
             fcV[v.unit], mcV[v.unit], ccV[v.unit]);
    checkUnit($sformatf("v%0d", i), v.unit, v);
  endtask

  task automatic checkAllZero(input string tag);
    vec_t z;
    z = mkV(0, OP_NOP, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 32'h0, 32'h0);
    for (int u = 0; u < NU; u++) begin
      $display("%s unit=%0d busy=%0b done=%0b pass=%0b fc=%0d mc=%0d cc=%0d",
               tag, u, busyV[u], doneV[u], passV[u], fcV[u], mcV[u], ccV[u]);
      checkUnit($sformatf("%s.u%0d", tag, u), u, z);
    end
  endtask

  initial begin
    int seg1;
    reset_n = 1'b1; startV = '0; weV = '0; expIdx = 1'b0; expAddr = '0; expData = '0;
    memWrite = 1'b0; dataAddr = '0; writeData = '0;

    // unit, op, idx, addr, data, n | busy, done, pass, fc, mc, cc, fail_addr, fail_data
    // Single entry (0x0,7); idx 1 is out of range and must not touch entry 0.
    vq.push_back(mkV(UA, OP_LOAD,  1'b0, 32'h0,  32'd7, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_LOAD,  1'b1, 32'h0,  32'd9, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_NOP,   1'b0, 32'h0,  32'd0, 9,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd9,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_WR,    1'b0, 32'h0,  32'd7, 1,  1'b0,1'b1,1'b1, 2'd0,2'd1, 16'd10, 32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_WR,    1'b0, 32'h0,  32'd5, 1,  1'b0,1'b1,1'b1, 2'd0,2'd1, 16'd10, 32'h0,  32'h0));
    // Data mismatch on a known address.
    vq.push_back(mkV(UA, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_WR,    1'b0, 32'h0,  32'd5, 1,  1'b0,1'b1,1'b0, 2'd1,2'd0, 16'd1,  32'h0,  32'd5));
    // Watchdog expiry with no writes, then a final match on the last allowed cycle.
    vq.push_back(mkV(UA, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_NOP,   1'b0, 32'h0,  32'd0, 19, 1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd19, 32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_NOP,   1'b0, 32'h0,  32'd0, 1,  1'b0,1'b1,1'b0, 2'd3,2'd0, 16'd20, 32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_NOP,   1'b0, 32'h0,  32'd0, 5,  1'b0,1'b1,1'b0, 2'd3,2'd0, 16'd20, 32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_NOP,   1'b0, 32'h0,  32'd0, 19, 1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd19, 32'h0,  32'h0));
    vq.push_back(mkV(UA, OP_WR,    1'b0, 32'h0,  32'd7, 1,  1'b0,1'b1,1'b1, 2'd0,2'd1, 16'd20, 32'h0,  32'h0));
    // Ordered, lenient: out-of-order and unknown writes are ignored.
    vq.push_back(mkV(UB, OP_LOAD,  1'b0, 32'h4,  32'd1, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_LOAD,  1'b1, 32'h8,  32'd2, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd2,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h54, 32'd3, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd3,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd4,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b0,1'b1,1'b1, 2'd0,2'd2, 16'd5,  32'h0,  32'h0));
    // Unordered, strict.
    vq.push_back(mkV(UC, OP_LOAD,  1'b0, 32'h4,  32'd1, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_LOAD,  1'b1, 32'h8,  32'd2, 1,  1'b0,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b0,1'b1,1'b1, 2'd0,2'd2, 16'd2,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h54, 32'd3, 1,  1'b0,1'b1,1'b0, 2'd2,2'd0, 16'd1,  32'h54, 32'd3));
    vq.push_back(mkV(UC, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b0,1'b1,1'b0, 2'd2,2'd1, 16'd2,  32'h8,  32'd2));
    vq.push_back(mkV(UC, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UC, OP_WR,    1'b0, 32'h8,  32'd7, 1,  1'b0,1'b1,1'b0, 2'd1,2'd0, 16'd1,  32'h8,  32'd7));
    // Table load attempted mid-run must be ignored.
    vq.push_back(mkV(UB, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_LOAD,  1'b0, 32'h4,  32'd5, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd2,  32'h0,  32'h0));
    seg1 = vq.size();
    // After the mid-run reset: table retained, restart inside RUN clears progress.
    vq.push_back(mkV(UB, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_START, 1'b0, 32'h0,  32'd0, 1,  1'b1,1'b0,1'b0, 2'd0,2'd0, 16'd0,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h4,  32'd1, 1,  1'b1,1'b0,1'b0, 2'd0,2'd1, 16'd1,  32'h0,  32'h0));
    vq.push_back(mkV(UB, OP_WR,    1'b0, 32'h8,  32'd2, 1,  1'b0,1'b1,1'b1, 2'd0,2'd2, 16'd2,  32'h0,  32'h0));

    #2 reset_n = 1'b0;
    #30;
    checkAllZero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < seg1; i++) runVec(i);

    // Asynchronous reset mid-run: outputs must clear before the next clock edge.
    #2 reset_n = 1'b0;
    #1 checkAllZero("midreset");
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = seg1; i < vq.size(); i++) runVec(i);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
